// File: rtl/pipe_stage_reg.sv
// pipe_stage_reg: one-entry pipeline stage register with valid/ready handshake,
// flush, and a saturating stall counter.
// With SKID_BUFFER_EN defined, a second (skid) entry is added.
// In that build in_ready depends only on registered state, so there is no
// combinational path from out_ready to in_ready.
module pipe_stage_reg #(
   parameter int               WIDTH     = 32,
   parameter logic [WIDTH-1:0] RESET_VAL = '0,
   parameter int               CNT_W     = 8
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             flush,
   input  logic             in_valid,
   input  logic [WIDTH-1:0] in_data,
   output logic             in_ready,
   output logic             out_valid,
   output logic [WIDTH-1:0] out_data,
   input  logic             out_ready,
   output logic [CNT_W-1:0] stall_cnt,
   input  logic             stall_clr
);

   // SKID is only reachable when the skid entry is built in
   typedef enum logic [1:0] {
      EMPTY = 2'd0,
      FULL  = 2'd1,
      SKID  = 2'd2
   } state_t;

   state_t           state_reg, state_next;
   logic [WIDTH-1:0] data_reg, data_next;
   logic [CNT_W-1:0] cnt_reg, cnt_next;
   logic             in_xfer, out_xfer;

`ifdef SKID_BUFFER_EN
   logic [WIDTH-1:0] skid_reg, skid_next;
   logic             skid_valid;

   assign skid_valid = (state_reg == SKID);
   // Accept whenever the skid slot is free; flush always drains the beat
   assign in_ready   = flush || !skid_valid;
`else
   // Combinational ready: space exists now or the held beat leaves this edge
   assign in_ready   = flush || !out_valid || out_ready;
`endif

   assign out_valid = (state_reg != EMPTY);
   assign out_data  = data_reg;
   assign stall_cnt = cnt_reg;
   assign in_xfer   = in_valid && in_ready;
   assign out_xfer  = out_valid && out_ready;

   // Next-state and payload selection; flush overrides every transfer
   always_comb begin
      state_next = state_reg;
      data_next  = data_reg;
`ifdef SKID_BUFFER_EN
      skid_next  = skid_reg;
`endif
      if (flush) begin
         state_next = EMPTY;
         data_next  = RESET_VAL;
      end else begin
         case (state_reg)
            EMPTY: begin
               if (in_xfer) begin
                  state_next = FULL;
                  data_next  = in_data;
               end
            end
            FULL: begin
               if (out_xfer && in_xfer) begin
                  data_next = in_data;
               end else if (out_xfer) begin
                  // out_data intentionally keeps the last value
                  state_next = EMPTY;
`ifdef SKID_BUFFER_EN
               end else if (in_xfer) begin
                  // downstream stalled: park the new beat behind the held one
                  state_next = SKID;
                  skid_next  = in_data;
`endif
               end
            end
`ifdef SKID_BUFFER_EN
            SKID: begin
               if (out_xfer) begin
                  state_next = FULL;
                  data_next  = skid_reg;
               end
            end
`endif
            default: begin
               state_next = EMPTY;
               data_next  = RESET_VAL;
            end
         endcase
      end
   end

   // Stall counter: clear wins over increment, saturates at all-ones
   always_comb begin
      cnt_next = cnt_reg;
      if (stall_clr) begin
         cnt_next = '0;
      end else if (out_valid && !out_ready && !flush && (cnt_reg != {CNT_W{1'b1}})) begin
         cnt_next = cnt_reg + CNT_W'(1);
      end
   end

   // State registers; reset discards any payload in flight
   always_ff @(posedge clk) begin
      if (reset) begin
         state_reg <= EMPTY;
         data_reg  <= RESET_VAL;
         cnt_reg   <= '0;
`ifdef SKID_BUFFER_EN
         skid_reg  <= RESET_VAL;
`endif
      end else begin
         state_reg <= state_next;
         data_reg  <= data_next;
         cnt_reg   <= cnt_next;
`ifdef SKID_BUFFER_EN
         skid_reg  <= skid_next;
`endif
      end
   end

endmodule
